// File: rtl/video_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : video_mem_arb
//  Purpose  : Slot scheduler that shares one DRAM port between the video fetcher
//             and a DMA requester, and steers read strobes back to their owner.
//  Revision : 1.0  initial release
// ============================================================================
module video_mem_arb #(
    parameter int RD_LAT = 2,
    parameter int STARVE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cend,
    input  logic        pre_cend,
    input  logic        vid_go,
    input  logic [1:0]  vid_bw,
    input  logic [20:0] vid_addr,
    output logic        vid_next,
    output logic        vid_strobe,
    input  logic        dma_req,
    input  logic [20:0] dma_addr,
    input  logic        dma_rnw,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic        dma_strobe,
    output logic        mem_req,
    output logic        mem_rnw,
    output logic [20:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [1:0] c_own_none = 2'd0;
    localparam logic [1:0] c_own_vid  = 2'd1;
    localparam logic [1:0] c_own_dma  = 2'd2;

    localparam bit c_starve_en  = (STARVE > 0);
    localparam int c_starve_max = (STARVE > 0) ? STARVE - 1 : 0;
    localparam int c_sw         = (c_starve_max > 0) ? $clog2(c_starve_max + 1) : 1;
    localparam logic [c_sw-1:0] c_starve_lim = c_sw'(c_starve_max);

    logic [2:0]      r_ph;
    logic [1:0]      r_win;
    logic [c_sw-1:0] r_starve;
    logic [1:0]      r_tag [RD_LAT];

    logic            r_vid_next;
    logic            r_dma_ack;
    logic            r_mem_req;
    logic            r_mem_rnw;
    logic [20:0]     r_mem_addr;
    logic [15:0]     r_mem_wdata;

    logic [2:0]      w_slot_ph;
    logic            w_vid_elig;
    logic            w_override;
    logic [1:0]      w_dec;
    logic [1:0]      w_tag_in;
    logic [1:0]      w_tag_out;

    // Read data is consumed by the requesters themselves; only its timing matters here.
    logic            w_unused;
    assign w_unused = ^mem_rdata;

    // The decision is for the slot starting at the next cend, whose phase is ph+1.
    assign w_slot_ph = r_ph + 3'd1;

    always_comb begin
        w_vid_elig = 1'b0;
        case (vid_bw)
            2'b00:   w_vid_elig = (w_slot_ph == 3'd0);
            2'b01:   w_vid_elig = (w_slot_ph[1:0] == 2'd0);
            2'b10:   w_vid_elig = ~w_slot_ph[0];
            default: w_vid_elig = 1'b1;
        endcase
    end

    assign w_override = c_starve_en && (vid_bw == 2'b11) && dma_req && (r_starve == c_starve_lim);

    always_comb begin
        w_dec = c_own_none;
        if (vid_go && w_vid_elig && !w_override) begin
            w_dec = c_own_vid;
        end else if (dma_req) begin
            w_dec = c_own_dma;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= c_own_none;
        end else if (pre_cend) begin
            r_win <= w_dec;
        end else if (cend) begin
            r_win <= c_own_none;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph        <= 3'd0;
            r_vid_next  <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_rnw   <= 1'b0;
            r_mem_addr  <= 21'd0;
            r_mem_wdata <= 16'd0;
        end else if (cend) begin
            r_ph       <= r_ph + 3'd1;
            r_vid_next <= (r_win == c_own_vid);
            r_dma_ack  <= (r_win == c_own_dma);
            case (r_win)
                c_own_vid: begin
                    r_mem_req  <= 1'b1;
                    r_mem_rnw  <= 1'b1;
                    r_mem_addr <= vid_addr;
                end
                c_own_dma: begin
                    r_mem_req   <= 1'b1;
                    r_mem_rnw   <= dma_rnw;
                    r_mem_addr  <= dma_addr;
                    r_mem_wdata <= dma_wdata;
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end else begin
            r_vid_next <= 1'b0;
            r_dma_ack  <= 1'b0;
        end
    end

    // Counts slots DMA has lost to full-bandwidth video; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (!dma_req || !c_starve_en) begin
            r_starve <= '0;
        end else if (cend) begin
            if (r_win == c_own_dma) begin
                r_starve <= '0;
            end else if ((r_win == c_own_vid) && (vid_bw == 2'b11) && (r_starve != c_starve_lim)) begin
                r_starve <= r_starve + c_sw'(1);
            end
        end
    end

    always_comb begin
        w_tag_in = c_own_none;
        if (r_win == c_own_vid) begin
            w_tag_in = c_own_vid;
        end else if ((r_win == c_own_dma) && dma_rnw) begin
            w_tag_in = c_own_dma;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= c_own_none;
            end
        end else if (cend) begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_tag[0] <= w_tag_in;
        end
    end

    assign w_tag_out = r_tag[RD_LAT-1];

    assign vid_strobe = cend && (w_tag_out == c_own_vid);
    assign dma_strobe = cend && (w_tag_out == c_own_dma);
    assign vid_next   = r_vid_next;
    assign dma_ack    = r_dma_ack;
    assign mem_req    = r_mem_req;
    assign mem_rnw    = r_mem_rnw;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_video_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_mem_arb
//  Purpose  : Directed self-checking bench for video_mem_arb.
//  Revision : 1.0  initial release
// ============================================================================
module tb_video_mem_arb;

    localparam int RD_LAT = 2;
    localparam int STARVE = 16;

    logic        clk;
    logic        rst_n;
    logic        cend;
    logic        pre_cend;
    logic        vid_go;
    logic [1:0]  vid_bw;
    logic [20:0] vid_addr;
    logic        vid_next;
    logic        vid_strobe;
    logic        dma_req;
    logic [20:0] dma_addr;
    logic        dma_rnw;
    logic [15:0] dma_wdata;
    logic        dma_ack;
    logic        dma_strobe;
    logic        mem_req;
    logic        mem_rnw;
    logic [20:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int checks   = 0;
    int failures = 0;
    int acc_vn, acc_ack, acc_vs, acc_ds, acc_req;
    int sc;

    video_mem_arb #(.RD_LAT(RD_LAT), .STARVE(STARVE)) dut (
        .clk(clk), .rst_n(rst_n), .cend(cend), .pre_cend(pre_cend),
        .vid_go(vid_go), .vid_bw(vid_bw), .vid_addr(vid_addr),
        .vid_next(vid_next), .vid_strobe(vid_strobe),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_rnw(dma_rnw),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_strobe(dma_strobe),
        .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Four-clock slots: pre_cend in the third clock, cend in the fourth.
    initial begin
        sc       = 0;
        cend     = 1'b0;
        pre_cend = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sc       = (sc + 1) % 4;
            pre_cend = (sc == 2);
            cend     = (sc == 3);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(negedge clk);
    endtask

    // Advance through n cend cycles, accumulating pulses seen on the way.
    task automatic step_slots(input int n);
        int k   = 0;
        int cyc = 0;
        acc_vn = 0; acc_ack = 0; acc_vs = 0; acc_ds = 0; acc_req = 0;
        while (k < n && cyc < n * 8 + 16) begin
            @(negedge clk);
            cyc++;
            acc_vn  += int'(vid_next);
            acc_ack += int'(dma_ack);
            acc_vs  += int'(vid_strobe);
            acc_ds  += int'(dma_strobe);
            acc_req += int'(mem_req);
            if (cend) k++;
        end
        if (k < n) begin
            checks++;
            failures++;
            $display("FAIL slot_timeout observed=%0d expected=%0d", k, n);
        end
    endtask

    initial begin
        rst_n = 1'b0; vid_go = 1'b0; vid_bw = 2'b00; vid_addr = '0;
        dma_req = 1'b0; dma_addr = '0; dma_rnw = 1'b1; dma_wdata = '0; mem_rdata = '0;

        // Reset with cend running
        repeat (10) step_clk();
        check("rst_mem_req",    32'(mem_req),    32'd0);
        check("rst_mem_rnw",    32'(mem_rnw),    32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_wdata",  32'(mem_wdata),  32'd0);
        check("rst_vid_next",   32'(vid_next),   32'd0);
        check("rst_dma_ack",    32'(dma_ack),    32'd0);
        check("rst_strobes",    32'({vid_strobe, dma_strobe}), 32'd0);
        rst_n = 1'b1;
        step_slots(1);
        step_slots(4);
        check("idle_mem_req", 32'(acc_req), 32'd0);
        check("idle_grants",  32'(acc_vn + acc_ack), 32'd0);

        // Bandwidth shares with DMA always requesting
        vid_addr = 21'h00200; dma_addr = 21'h00100; dma_rnw = 1'b1;
        vid_go = 1'b1; dma_req = 1'b1; vid_bw = 2'b00;
        step_slots(1);
        step_slots(8);
        check("bw8_vid", 32'(acc_vn),  32'd1);
        check("bw8_dma", 32'(acc_ack), 32'd7);
        vid_bw = 2'b01;
        step_slots(1);
        step_slots(8);
        check("bw4_vid", 32'(acc_vn),  32'd2);
        check("bw4_dma", 32'(acc_ack), 32'd6);
        vid_bw = 2'b10;
        step_slots(1);
        step_slots(8);
        check("bw2_vid", 32'(acc_vn),  32'd4);
        check("bw2_dma", 32'(acc_ack), 32'd4);

        // Single video read and its return latency
        vid_go = 1'b0; dma_req = 1'b0;
        step_slots(RD_LAT + 2);
        vid_bw = 2'b11; vid_go = 1'b1; vid_addr = 21'h0ABCD;
        step_slots(1);
        vid_go = 1'b0;
        step_slots(1);
        check("lat_vid_next", 32'(acc_vn),   32'd1);
        check("lat_early_vs", 32'(acc_vs),   32'd0);
        check("lat_mem_req",  32'(mem_req),  32'd1);
        check("lat_mem_rnw",  32'(mem_rnw),  32'd1);
        check("lat_mem_addr", 32'(mem_addr), 32'h0ABCD);
        mem_rdata = 16'hA5C3;
        step_slots(1);
        check("lat_vs_count", 32'(acc_vs),     32'd1);
        check("lat_vs_at_cend", 32'(vid_strobe), 32'd1);
        check("lat_ds",       32'(acc_ds),     32'd0);
        check("lat_no_vn",    32'(acc_vn),     32'd0);

        // DMA write
        dma_rnw = 1'b0; dma_addr = 21'h1F000; dma_wdata = 16'h1234; dma_req = 1'b1;
        step_slots(1);
        step_clk();
        check("wr_ack",       32'(dma_ack),   32'd1);
        check("wr_mem_req",   32'(mem_req),   32'd1);
        check("wr_mem_rnw",   32'(mem_rnw),   32'd0);
        check("wr_mem_addr",  32'(mem_addr),  32'h1F000);
        check("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
        dma_req = 1'b0;
        step_slots(4);
        check("wr_single_ack", 32'(acc_ack), 32'd0);
        check("wr_no_strobe",  32'(acc_vs + acc_ds), 32'd0);
        check("wr_idle_req",   32'(mem_req),   32'd0);
        check("wr_idle_addr",  32'(mem_addr),  32'h1F000);
        check("wr_idle_wdata", 32'(mem_wdata), 32'h1234);

        // Starvation override at full bandwidth
        dma_rnw = 1'b1; dma_addr = 21'h00300; vid_addr = 21'h00400;
        vid_bw = 2'b11; vid_go = 1'b1; dma_req = 1'b1;
        step_slots(1);
        for (int i = 0; i < 32; i++) begin
            step_slots(1);
            check($sformatf("starve_ack_%0d", i), 32'(acc_ack), (i % 16 == 15) ? 32'd1 : 32'd0);
            check($sformatf("starve_vn_%0d", i),  32'(acc_vn),  (i % 16 == 15) ? 32'd0 : 32'd1);
        end

        // vid_go drop with video reads in flight
        dma_req = 1'b0;
        step_slots(RD_LAT + 1);
        step_clk();
        vid_go = 1'b0;
        step_slots(4);
        check("drop_vs",      32'(acc_vs),  32'(RD_LAT));
        check("drop_no_vn",   32'(acc_vn),  32'd0);
        check("drop_ds",      32'(acc_ds),  32'd0);
        check("drop_mem_req", 32'(mem_req), 32'd0);

        // Reset mid-operation discards in-flight tags
        vid_go = 1'b1; dma_req = 1'b1; dma_rnw = 1'b1;
        step_slots(3);
        step_clk();
        rst_n = 1'b0;
        step_clk();
        check("mid_rst_req",  32'(mem_req),  32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_vn",   32'({vid_next, dma_ack}), 32'd0);
        vid_go = 1'b0; dma_req = 1'b0;
        step_clk();
        rst_n = 1'b1;
        step_slots(4);
        check("post_rst_vs",  32'(acc_vs),  32'd0);
        check("post_rst_ds",  32'(acc_ds),  32'd0);
        check("post_rst_req", 32'(acc_req), 32'd0);
        vid_go = 1'b1;
        step_slots(1);
        step_slots(1);
        check("post_rst_resume", 32'(acc_vn), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
